// File: rtl/pwm_sampler_mc.sv
// Multi-channel PWM generator fed by a frame FIFO that is sampled once per sample period.
// Define PWM_SAMPLER_MC_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_count output.
module pwm_sampler_mc #(
  parameter int CODE_WIDTH        = 10,
  parameter int CYCLES_PER_SAMPLE = 2500,
  parameter int NUM_CH            = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [NUM_CH*CODE_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic [NUM_CH-1:0]            pwm_out,
  output logic                         sample_tick,
`ifdef PWM_SAMPLER_MC_UNDERRUN_CNT_EN
  output logic                         underrun,
  output logic [15:0]                  underrun_count
`else
  output logic                         underrun
`endif
);

  localparam int FW = NUM_CH * CODE_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(CYCLES_PER_SAMPLE);
  localparam logic [SW-1:0]         SCNT_LAST = SW'(CYCLES_PER_SAMPLE - 1);
  localparam logic [SW-1:0]         SCNT_PRE  = SW'(CYCLES_PER_SAMPLE - 2);
  localparam logic [PW:0]           FULL      = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CODE_WIDTH-1:0] WCNT_LAST = {CODE_WIDTH{1'b1}};

  logic [CODE_WIDTH-1:0] wcnt;
  logic [SW-1:0]         scnt;
  logic                  tick_r;
  logic                  ready_r;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [PW:0]           count_next;
  logic [FW-1:0]         mem [FIFO_DEPTH];
  logic [FW-1:0]         shadow_code;
  logic [FW-1:0]         window_code;
  logic [NUM_CH-1:0]     pwm_r;
  logic                  push;
  logic                  pop;

  assign push        = in_valid && ready_r && !rst;
  assign pop         = tick_r && (count != {(PW + 1){1'b0}});
  assign underrun    = tick_r && (count == {(PW + 1){1'b0}});
  assign in_ready    = ready_r;
  assign sample_tick = tick_r;
  assign pwm_out     = pwm_r;

  // Free-running window and sample counters; tick is registered one step ahead of scnt
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt   <= {CODE_WIDTH{1'b0}};
      scnt   <= {SW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      wcnt   <= wcnt + CODE_WIDTH'(1);
      scnt   <= (scnt == SCNT_LAST) ? {SW{1'b0}} : scnt + SW'(1);
      tick_r <= (scnt == SCNT_PRE);
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PW + 1)'(1);
      2'b01:   count_next = count - (PW + 1)'(1);
      default: count_next = count;
    endcase
  end

  // FIFO control; ready is registered so it never depends on in_valid or the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= {PW{1'b0}};
      rd_ptr  <= {PW{1'b0}};
      count   <= {(PW + 1){1'b0}};
      ready_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next;
      ready_r <= (count_next != FULL);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Shadow takes the popped frame; window codes only change at the window seam
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_code <= {FW{1'b0}};
      window_code <= {FW{1'b0}};
      pwm_r       <= {NUM_CH{1'b0}};
    end else begin
      if (pop) shadow_code <= mem[rd_ptr];
      if (wcnt == WCNT_LAST) window_code <= shadow_code;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_r[i] <= (wcnt < window_code[i*CODE_WIDTH +: CODE_WIDTH]);
      end
    end
  end

`ifdef PWM_SAMPLER_MC_UNDERRUN_CNT_EN
  logic [15:0] ucnt_r;

  // Saturating underrun event counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_r <= 16'h0000;
    end else if (underrun && (ucnt_r != 16'hFFFF)) begin
      ucnt_r <= ucnt_r + 16'h0001;
    end
  end

  assign underrun_count = ucnt_r;
`endif

endmodule

// File: doc/pwm_sampler_mc.md
PWM_SAMPLER_MC -- requirements
Module: pwm_sampler_mc

Interface
REQ-001 SHALL have parameter CODE_WIDTH, 10, code width; PWM window = 2**CODE_WIDTH cycles.
REQ-002 SHALL have parameter CYCLES_PER_SAMPLE, 2500, sample period in clk cycles; legal range >= 2.
REQ-003 SHALL have parameter NUM_CH, 2, number of PWM channels; legal range >= 1.
REQ-004 SHALL have parameter FIFO_DEPTH, 4, sample frames buffered; power of 2, >= 2.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  frame on in_data is valid.
REQ-008 SHALL have port in_data  input  NUM_CH*CODE_WIDTH  frame; channel i at bits [i*CODE_WIDTH +: CODE_WIDTH].
REQ-009 SHALL have port in_ready  output  1  FIFO can accept a frame this cycle.
REQ-010 SHALL have port pwm_out  output  NUM_CH  registered PWM output, bit i = channel i.
REQ-011 SHALL have port sample_tick  output  1  one-cycle pulse marking each sample boundary.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse: sample boundary with FIFO empty.

Function
REQ-013 Window counter wcnt SHALL count 0..2**CODE_WIDTH-1 every cycle, then wrap to 0.
REQ-014 Sample counter scnt SHALL count 0..CYCLES_PER_SAMPLE-1 every cycle, then wrap to 0; independent of wcnt.
REQ-015 sample_tick SHALL be high exactly while scnt == CYCLES_PER_SAMPLE-1.
REQ-016 Transfer SHALL occur when in_valid && in_ready; frame written to FIFO tail.
REQ-017 in_ready SHALL be low when FIFO holds FIFO_DEPTH frames, high otherwise; decoded from registered state only (no combinational path from in_valid or sample_tick).
REQ-018 On sample_tick with FIFO non-empty: head frame popped into per-channel shadow code registers, valid the next cycle.
REQ-019 On sample_tick with FIFO empty: underrun pulse same cycle; shadow codes hold previous values.
REQ-020 Simultaneous push and pop: both occur; count unchanged. A full FIFO SHALL NOT accept in that cycle, even with a pop (no pass-through).
REQ-021 Push into empty FIFO coincident with sample_tick: underrun asserted; pushed frame stored, popped at next tick (no bypass).
REQ-022 Window code registers SHALL load from shadow registers only when wcnt == 2**CODE_WIDTH-1, so a new code takes effect at wcnt == 0; no mid-window code change.
REQ-023 pwm_out[i] SHALL be registered: next value = (wcnt < window_code[i]), unsigned compare.
REQ-024 Code 0 SHALL give constant low; code 2**CODE_WIDTH-1 SHALL give high for 2**CODE_WIDTH-1 of every 2**CODE_WIDTH cycles.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-026 While rst high: wcnt, scnt, FIFO count/pointers, shadow and window codes SHALL clear to 0.
REQ-027 While rst high: pwm_out, sample_tick, underrun and in_ready SHALL be 0; in_ready rises the first cycle after rst falls.
REQ-028 Reset mid-operation SHALL discard all buffered frames; no frame accepted in a rst cycle.

Configuration
REQ-029 Macro PWM_SAMPLER_MC_UNDERRUN_CNT_EN defined: SHALL add output underrun_count (16 bits), incremented per underrun pulse, saturating at 16'hFFFF, cleared by rst.
REQ-030 Macro undefined: underrun_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 CODE_WIDTH=4, NUM_CH=2, push {ch1=0, ch0=5}, wait tick -> from next window start ch0 high 5 of every 16 cycles, ch1 constant low.
REQ-032 FIFO_DEPTH=4, in_valid held high with no ticks -> exactly 4 frames accepted, in_ready low; after one tick in_ready high, 5th frame accepted.
REQ-033 FIFO empty, CYCLES_PER_SAMPLE=20 -> underrun pulses every 20 cycles, sample_tick coincident, pwm duty unchanged; with macro, underrun_count = 3 after 3 ticks.
REQ-034 Change code 3->12 (CODE_WIDTH=4) with tick at wcnt=7 -> current window finishes at duty 3; duty 12 from next wcnt=0.
REQ-035 Assert rst for 1 cycle with 3 frames buffered -> pwm_out 0, FIFO empty, next tick reports underrun.
